bus_term_arbiter: RTL and testbench
===================================

# bus_term_arbiter

Round-robin arbiter that shares the single output node of the `cv_bus_term` cell between `NREQ` requesters by driving exactly one bit of its gate bus `in[NREQ-1:0]` at a time. It enforces a break-before-make dead period between owners and a maximum hold time per grant. The block sits in the digital control domain directly in front of the bus-terminated cell, and its `gate_out` bus connects bit-for-bit to the cell's `in` bus.

## Interface
- `NREQ`, 2, number of requesters; equals the gate-bus width of the driven cell; must be ≥ 2.
- `DEAD_CYC`, 1, all-zero gate cycles inserted between two grants; must be ≥ 1.
- `MAX_HOLD`, 16, maximum consecutive cycles one owner may hold a grant; must be ≥ 1.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `req`  input  NREQ  level request per requester; bit i belongs to requester i.
- `gate_out`  output  NREQ  registered gate drive; one-hot or all-zero; connects to the cell's `in` bus.
- `grant_id`  output  $clog2(NREQ)  index of the current owner; valid only while `busy`=1.
- `busy`  output  1  high while the FSM is in DRIVE.
- `preempt`  output  1  one-cycle pulse on the edge where a grant ends because `MAX_HOLD` expired.

## Operation
- FSM states: IDLE, DRIVE, DEAD. Reset state is IDLE.
- IDLE: if `req` is nonzero, the next state is DRIVE. The owner is the first set bit found by searching upward from round-robin pointer `ptr`, wrapping modulo NREQ. `gate_out` becomes one-hot on the owner, and the hold counter loads 1.
- DRIVE: `gate_out` and `grant_id` stay stable. Each cycle, the hold counter increments while `req[owner]`=1.
  - If `req[owner]`=0, the grant is released and the next state is DEAD.
  - If `req[owner]`=1 and the counter equals MAX_HOLD, the grant is released, `preempt` pulses, and the next state is DEAD.
  - On either release, `ptr` is set to (owner+1) mod NREQ and `gate_out` goes to 0.
- DEAD: `gate_out`=0 for exactly DEAD_CYC cycles, counted by the dead counter; then the FSM returns to IDLE. Requests are ignored during DEAD.
- `gate_out` never has two bits set. It never goes directly from one nonzero value to another; at least DEAD_CYC zero cycles always separate two grants.
- Requests on non-owner bits during DRIVE are ignored; they do not affect the hold count.
- Width rules:
  - Hold counter is $clog2(MAX_HOLD+1) bits and saturates at MAX_HOLD.
  - Dead counter is $clog2(DEAD_CYC+1) bits.
  - `ptr` is $clog2(NREQ) bits, and the wrap at NREQ-1 goes to 0 (handles NREQ not a power of two).

## Timing
- Reset values: `gate_out`=0, `grant_id`=0, `busy`=0, `preempt`=0, `ptr`=0, both counters 0.
- `rst` asserted in any state forces the reset values on the next edge; it overrides a DRIVE or DEAD in progress. No dead period is owed after reset.
- Grant latency: `req` sampled high in IDLE at edge n gives `gate_out` one-hot after edge n (visible in cycle n+1).
- Release latency: `req[owner]` sampled low at edge n gives `gate_out`=0 after edge n.
- A grant held to the limit lasts exactly MAX_HOLD cycles. `preempt` is high in the first DEAD cycle only.
- Back-to-back: with continuous requests, the period between grant starts is grant length + DEAD_CYC + 1 (one IDLE arbitration cycle).
- The owner re-requests in the same cycle it drops its request: this counts as a release; round-robin advances.
- All outputs are registered; there is no combinational path from `req` to any output.

## Structure
- Package `bus_term_arb_pkg` holds:
  - the state enum type (IDLE, DRIVE, DEAD);
  - default constants for NREQ, DEAD_CYC and MAX_HOLD;
  - a width helper function for the counters.
- Sub-module `rr_pick`: a combinational round-robin priority picker.
  - Inputs: `req[NREQ-1:0]`, `ptr`.
  - Outputs: `found`, `idx`.
  - Instantiated once in the IDLE arbitration path.
- All remaining logic (FSM, counters, output registers) lives in the top module.

## Test plan
- Reset mid-grant: `rst` pulsed while in DRIVE with `gate_out`=2'b10 → after the next edge `gate_out`=0, `busy`=0, `ptr`=0; with `req`=2'b11 next, the first grant is bit 0.
- Single requester: `req`=2'b01 held for 3 cycles, then dropped → `gate_out`=01 for 3 cycles, 0 for DEAD_CYC=1 cycle, then IDLE; `preempt` stays 0.
- Round-robin fairness: `req`=2'b11 held constant with MAX_HOLD=4 → grants alternate 01,10,01,… with 4 cycles each; `preempt` pulses on every release; never more than one bit set; a gap of at least 1 zero cycle every time.
- Preemption boundary: MAX_HOLD=1, `req`=2'b10 constant → `gate_out`=10 for exactly 1 cycle, then 0 for 2 cycles (DEAD + IDLE), repeating.
- Dead-period request: requester 1 raises `req` during DEAD → no grant before IDLE; grant appears one cycle after IDLE is entered.
- NREQ=3 wrap: owner 2 releases with `req`=3'b101 → next grant goes to bit 0 (`ptr` wraps 2→0); a property check holds `$onehot0(gate_out)` throughout.

Source files
------------

// File: rtl/bus_term_arb_pkg.sv
// rtl/bus_term_arb_pkg.sv - shared types, defaults and width helper for bus_term_arbiter
package bus_term_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DEAD  = 2'd2
   } arb_state_e;

   localparam int NREQ_DEF     = 2;
   localparam int DEAD_CYC_DEF = 1;
   localparam int MAX_HOLD_DEF = 16;

   // Bits needed to count from 0 up to and including max_val.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/bus_term_arbiter_rr_pick.sv
// rtl/bus_term_arbiter_rr_pick.sv - combinational round-robin picker
// Returns the first set request at or above ptr, wrapping past NREQ-1 to 0.
module rr_pick #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req,
   input  logic [$clog2(NREQ)-1:0] ptr,
   output logic                    found,
   output logic [$clog2(NREQ)-1:0] idx
);
   localparam int IW = $clog2(NREQ);
   localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

   logic [IW-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = ptr;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
         // Explicit wrap keeps non-power-of-two NREQ from reaching unused codes.
         cand = (cand == LAST_IDX) ? '0 : cand + IW'(1);
      end
   end

endmodule

// File: rtl/bus_term_arbiter.sv
// rtl/bus_term_arbiter.sv - round-robin gate-bus arbiter with dead time and hold limit
// Drives at most one gate bit; every ownership change passes through an all-zero dead period.
module bus_term_arbiter
   import bus_term_arb_pkg::*;
#(
   parameter int NREQ     = NREQ_DEF,
   parameter int DEAD_CYC = DEAD_CYC_DEF,
   parameter int MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         gate_out,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    preempt
);
   localparam int IW = $clog2(NREQ);
   localparam int HW = cnt_width(MAX_HOLD);
   localparam int DW = cnt_width(DEAD_CYC);
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
   localparam logic [DW-1:0] DEAD_LIM = DW'(DEAD_CYC);
   localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

   arb_state_e      state_q, state_d;
   logic [IW-1:0]   ptr_q, ptr_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [HW-1:0]   hold_q, hold_d;
   logic [DW-1:0]   dead_q, dead_d;
   logic [NREQ-1:0] gate_q, gate_d;
   logic            busy_q, busy_d;
   logic            preempt_q, preempt_d;

   logic            pick_found;
   logic [IW-1:0]   pick_idx;
   logic            owner_req;

   rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign owner_req = req[owner_q];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      owner_d   = owner_q;
      hold_d    = hold_q;
      dead_d    = dead_q;
      gate_d    = gate_q;
      busy_d    = busy_q;
      preempt_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = DRIVE;
               owner_d = pick_idx;
               gate_d  = NREQ'(1) << pick_idx;
               hold_d  = HW'(1);
               busy_d  = 1'b1;
            end
         end
         DRIVE: begin
            // A dropped request and an expired hold both release; only the latter is a preemption.
            if (!owner_req || hold_q == HOLD_LIM) begin
               state_d   = DEAD;
               preempt_d = owner_req;
               ptr_d     = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);
               gate_d    = '0;
               busy_d    = 1'b0;
               hold_d    = '0;
               dead_d    = DW'(1);
            end else begin
               hold_d = hold_q + HW'(1);
            end
         end
         DEAD: begin
            if (dead_q >= DEAD_LIM) begin
               state_d = IDLE;
               dead_d  = '0;
            end else begin
               dead_d = dead_q + DW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            gate_d  = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         hold_q    <= '0;
         dead_q    <= '0;
         gate_q    <= '0;
         busy_q    <= 1'b0;
         preempt_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         hold_q    <= hold_d;
         dead_q    <= dead_d;
         gate_q    <= gate_d;
         busy_q    <= busy_d;
         preempt_q <= preempt_d;
      end
   end

   assign gate_out = gate_q;
   assign grant_id = owner_q;
   assign busy     = busy_q;
   assign preempt  = preempt_q;

endmodule

// File: tb/tb_bus_term_arbiter.sv
// tb/tb_bus_term_arbiter.sv - bench for bus_term_arbiter against a behavioural model
module tb_bus_term_arbiter;

   typedef struct {
      int mode;       // 0 waiting, 1 granted, 2 in dead gap
      int owner;
      int held;
      int dead_left;
      int ptr;
      int gate;
      int busy;
      int preempt;
   } mdl_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_a = '0;
   logic [2:0] req_b = '0;

   logic [1:0] gate_a;
   logic [0:0] gid_a;
   logic       busy_a, pre_a;
   logic [2:0] gate_b;
   logic [1:0] gid_b;
   logic       busy_b, pre_b;

   int   n_cmp = 0;
   int   n_err = 0;
   bit   chk_en = 1'b0;
   mdl_t m_a, m_b;
   int   prev_a = 0;
   int   prev_b = 0;

   bus_term_arbiter #(.NREQ(2), .DEAD_CYC(1), .MAX_HOLD(4)) dut_a (
      .clk(clk), .rst(rst), .req(req_a),
      .gate_out(gate_a), .grant_id(gid_a), .busy(busy_a), .preempt(pre_a)
   );

   bus_term_arbiter #(.NREQ(3), .DEAD_CYC(2), .MAX_HOLD(1)) dut_b (
      .clk(clk), .rst(rst), .req(req_b),
      .gate_out(gate_b), .grant_id(gid_b), .busy(busy_b), .preempt(pre_b)
   );

   always #5 clk = ~clk;

   function automatic mdl_t step(mdl_t m, int rq, bit r, int n, int d, int h);
      mdl_t nx;
      nx = m;
      nx.preempt = 0;
      if (r) begin
         nx = '{default: 0};
         return nx;
      end
      if (m.mode == 0) begin
         for (int k = 0; k < n; k++) begin
            int c;
            c = (m.ptr + k) % n;
            if (((rq >> c) & 1) == 1) begin
               nx.mode  = 1;
               nx.owner = c;
               nx.held  = 1;
               nx.gate  = 1 << c;
               nx.busy  = 1;
               break;
            end
         end
      end else if (m.mode == 1) begin
         if (((rq >> m.owner) & 1) == 0 || m.held >= h) begin
            nx.mode      = 2;
            nx.preempt   = (rq >> m.owner) & 1;
            nx.ptr       = (m.owner + 1) % n;
            nx.gate      = 0;
            nx.busy      = 0;
            nx.dead_left = d;
         end else begin
            nx.held = m.held + 1;
         end
      end else begin
         nx.dead_left = m.dead_left - 1;
         if (nx.dead_left == 0) nx.mode = 0;
      end
      return nx;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      m_a <= step(m_a, int'(req_a), rst, 2, 1, 4);
      m_b <= step(m_b, int'(req_b), rst, 3, 2, 1);
      if (rst) chk_en <= 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("a.gate", int'(gate_a), m_a.gate);
         chk("a.busy", int'(busy_a), m_a.busy);
         chk("a.preempt", int'(pre_a), m_a.preempt);
         if (m_a.busy == 1) chk("a.grant_id", int'(gid_a), m_a.owner);
         chk("a.onehot0", int'($onehot0(gate_a)), 1);
         chk("a.no_direct_switch", int'(prev_a != 0 && gate_a != 0 && int'(gate_a) != prev_a), 0);
         chk("b.gate", int'(gate_b), m_b.gate);
         chk("b.busy", int'(busy_b), m_b.busy);
         chk("b.preempt", int'(pre_b), m_b.preempt);
         if (m_b.busy == 1) chk("b.grant_id", int'(gid_b), m_b.owner);
         chk("b.onehot0", int'($onehot0(gate_b)), 1);
         chk("b.no_direct_switch", int'(prev_b != 0 && gate_b != 0 && int'(gate_b) != prev_b), 0);
         prev_a <= int'(gate_a);
         prev_b <= int'(gate_b);
      end
   end

   initial begin
      int exp_g;
      rst = 1'b1;
      tick();
      tick();
      chk("rst.gate_a", int'(gate_a), 0);
      chk("rst.busy_a", int'(busy_a), 0);
      chk("rst.preempt_a", int'(pre_a), 0);
      chk("rst.grant_id_a", int'(gid_a), 0);
      chk("rst.gate_b", int'(gate_b), 0);
      rst = 1'b0;

      // single requester held three cycles then dropped
      req_a = 2'b01;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("single.gate", int'(gate_a), 1);
         chk("single.grant_id", int'(gid_a), 0);
      end
      req_a = 2'b00;
      tick();
      chk("single.release_gate", int'(gate_a), 0);
      chk("single.release_preempt", int'(pre_a), 0);
      tick();
      chk("single.idle_busy", int'(busy_a), 0);

      // continuous contention: 4 on, 1 dead, 1 arbitration, alternating owners
      req_a = 2'b11;
      for (int i = 0; i < 14; i++) begin
         tick();
         exp_g = ((i % 6) < 4) ? (((i / 6) % 2 == 0) ? 2 : 1) : 0;
         chk("rr.gate", int'(gate_a), exp_g);
         chk("rr.preempt", int'(pre_a), int'((i % 6) == 4));
      end

      // reset while owner 1 is driving
      rst = 1'b1;
      tick();
      chk("rstmid.gate", int'(gate_a), 0);
      chk("rstmid.busy", int'(busy_a), 0);
      rst = 1'b0;
      tick();
      chk("rstmid.first_grant", int'(gate_a), 1);

      // request raised during the dead gap waits for arbitration
      req_a = 2'b00;
      tick();
      chk("deadreq.release", int'(gate_a), 0);
      req_a = 2'b10;
      tick();
      chk("deadreq.no_grant", int'(gate_a), 0);
      chk("deadreq.not_busy", int'(busy_a), 0);
      tick();
      chk("deadreq.grant", int'(gate_a), 2);
      req_a = 2'b00;
      for (int i = 0; i < 3; i++) tick();

      // three requesters: pointer wraps from 2 back to 0
      req_b = 3'b100;
      tick();
      chk("wrap.grant2", int'(gate_b), 4);
      req_b = 3'b101;
      tick();
      chk("wrap.preempt", int'(pre_b), 1);
      tick();
      tick();
      chk("wrap.idle_gate", int'(gate_b), 0);
      tick();
      chk("wrap.grant0", int'(gate_b), 1);

      // hold limit of one cycle: 1 on, 2 dead, 1 arbitration
      req_b = 3'b010;
      for (int t = 1; t <= 8; t++) begin
         tick();
         chk("hold1.gate", int'(gate_b), ((t % 4) == 0) ? 2 : 0);
         chk("hold1.preempt", int'(pre_b), int'(t == 5));
      end

      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(3) == 0) req_a = 2'($urandom);
         if ($urandom_range(3) == 0) req_b = 3'($urandom);
         rst = ($urandom_range(199) == 0);
         tick();
      end
      rst = 1'b0;
      tick();
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
